// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: FSM state codes,
// fetch redirect select codes and the fence drain counter width.
package pipe_hazard_ctrl_pkg;

  // FSM state encodings (legacy-compatible constant form)
  localparam logic [1:0] PHC_RUN         = 2'd0;
  localparam logic [1:0] PHC_MDU_WAIT    = 2'd1;
  localparam logic [1:0] PHC_FENCE_DRAIN = 2'd2;

  // Fetch redirect target select
  localparam logic [1:0] REDIR_BRANCH = 2'd0;
  localparam logic [1:0] REDIR_MTVEC  = 2'd1;
  localparam logic [1:0] REDIR_MEPC   = 2'd2;

  // Fence drain counter width (drain length legal 1..15)
  localparam int DRAIN_CNT_W = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard/event strobes from decode/execute and the per-stage pipeline
// controls returned by the sequencer. master = pipeline datapath side,
// slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
  import pipe_hazard_ctrl_pkg::*;

  // Events from ID / EX / mul-div unit
  logic       load_use_i;
  logic       branch_i;
  logic       fence_i;
  logic       exception_i;
  logic       mret_i;
  logic       ex_muldiv_i;
  logic       mdu_done_i;

  // Pipeline controls
  logic       stall_if_o;
  logic       stall_id_o;
  logic       stall_ex_o;
  logic       flush_id_o;
  logic       bubble_ex_o;
  logic       bubble_mem_o;
  logic       redirect_o;
  logic [1:0] redirect_sel_o;
  logic       mdu_start_o;

  modport master (
    output load_use_i, branch_i, fence_i, exception_i, mret_i,
           ex_muldiv_i, mdu_done_i,
    input  stall_if_o, stall_id_o, stall_ex_o, flush_id_o, bubble_ex_o,
           bubble_mem_o, redirect_o, redirect_sel_o, mdu_start_o
  );

  modport slave (
    input  load_use_i, branch_i, fence_i, exception_i, mret_i,
           ex_muldiv_i, mdu_done_i,
    output stall_if_o, stall_id_o, stall_ex_o, flush_id_o, bubble_ex_o,
           bubble_mem_o, redirect_o, redirect_sel_o, mdu_start_o
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// 32-bit free-running event counter: increments on each clock where en is
// high, wraps at 2^32, cleared by asynchronous active-low reset.
module pipe_perf_cnt (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  // Count enabled cycles
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count <= '0;
    else if (en) count <= count + 32'd1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer for the rv64IM five-stage core. Turns decode
// hazard strobes and the execute multi-cycle indication into per-stage
// stall/flush/bubble controls, the fetch redirect, and the mul/div start
// pulse. Optional performance counters under PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int FENCE_DRAIN_CYCLES = 3
) (
  input  logic                clock,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   hz
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]         perf_stall_cycles_o,
  output logic [31:0]         perf_redirects_o,
  output logic [31:0]         perf_mdu_ops_o
`endif
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(FENCE_DRAIN_CYCLES);

  logic [1:0]             state, state_nxt;
  logic [DRAIN_CNT_W-1:0] cnt, cnt_nxt;

  logic       stall_if, stall_id, stall_ex, flush_id;
  logic       bubble_ex, bubble_mem, redirect, mdu_start;
  logic [1:0] redirect_sel;

  // State and drain counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= PHC_RUN;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the
      // pre-edge values, so ordering inside this block cannot matter.
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and combinational pipeline controls
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    cnt_nxt      = cnt;
    stall_if     = 1'b0;
    stall_id     = 1'b0;
    stall_ex     = 1'b0;
    flush_id     = 1'b0;
    bubble_ex    = 1'b0;
    bubble_mem   = 1'b0;
    redirect     = 1'b0;
    redirect_sel = REDIR_BRANCH;
    mdu_start    = 1'b0;

    unique case (state)
      PHC_RUN: begin
        if (hz.ex_muldiv_i) begin
          // Start the MDU and freeze IF..EX; ID events wait until done
          mdu_start  = 1'b1;
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          stall_ex   = 1'b1;
          bubble_mem = 1'b1;
          state_nxt  = PHC_MDU_WAIT;
        end else if (hz.exception_i || hz.mret_i) begin
          redirect     = 1'b1;
          redirect_sel = hz.exception_i ? REDIR_MTVEC : REDIR_MEPC;
          flush_id     = 1'b1;
          bubble_ex    = 1'b1;
        end else if (hz.load_use_i) begin
          // Load-use masks any branch/fence seen in the same cycle
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
        end else if (hz.branch_i) begin
          redirect     = 1'b1;
          redirect_sel = REDIR_BRANCH;
          flush_id     = 1'b1;
        end else if (hz.fence_i) begin
          cnt_nxt   = DRAIN_LOAD;
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          bubble_ex = 1'b1;
          state_nxt = PHC_FENCE_DRAIN;
        end
      end

      PHC_MDU_WAIT: begin
        if (hz.mdu_done_i) begin
          // Result advances out of EX this cycle: release everything
          state_nxt = PHC_RUN;
        end else begin
          stall_if   = 1'b1;
          stall_id   = 1'b1;
          stall_ex   = 1'b1;
          bubble_mem = 1'b1;
        end
      end

      PHC_FENCE_DRAIN: begin
        cnt_nxt   = cnt - 1'b1;
        bubble_ex = 1'b1;
        if (cnt == DRAIN_CNT_W'(1)) begin
          // Last drain cycle: the fence itself retires as a NOP
          state_nxt = PHC_RUN;
        end else begin
          stall_if = 1'b1;
          stall_id = 1'b1;
        end
      end

      default: begin
        state_nxt = PHC_RUN;
        cnt_nxt   = '0;
      end
    endcase

    // Outputs are forced quiet while reset is held, even with live inputs
    if (!reset) begin
      stall_if     = 1'b0;
      stall_id     = 1'b0;
      stall_ex     = 1'b0;
      flush_id     = 1'b0;
      bubble_ex    = 1'b0;
      bubble_mem   = 1'b0;
      redirect     = 1'b0;
      redirect_sel = REDIR_BRANCH;
      mdu_start    = 1'b0;
    end
  end

  assign hz.stall_if_o     = stall_if;
  assign hz.stall_id_o     = stall_id;
  assign hz.stall_ex_o     = stall_ex;
  assign hz.flush_id_o     = flush_id;
  assign hz.bubble_ex_o    = bubble_ex;
  assign hz.bubble_mem_o   = bubble_mem;
  assign hz.redirect_o     = redirect;
  assign hz.redirect_sel_o = redirect_sel;
  assign hz.mdu_start_o    = mdu_start;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  pipe_perf_cnt u_perf_stall (
    .clock (clock),
    .reset (reset),
    .en    (stall_if),
    .count (perf_stall_cycles_o)
  );

  pipe_perf_cnt u_perf_redir (
    .clock (clock),
    .reset (reset),
    .en    (redirect),
    .count (perf_redirects_o)
  );

  pipe_perf_cnt u_perf_mdu (
    .clock (clock),
    .reset (reset),
    .en    (mdu_start),
    .count (perf_mdu_ops_o)
  );
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (FENCE_DRAIN_CYCLES=3).
// Each cycle the driver applies inputs and pushes the expected control
// vector; the monitor pops and compares at the falling edge.
// Expected vector bit order:
// [9] stall_if [8] stall_id [7] stall_ex [6] flush_id [5] bubble_ex
// [4] bubble_mem [3] redirect [2:1] redirect_sel [0] mdu_start
// Input vector bit order:
// [6] load_use [5] branch [4] fence [3] exception [2] mret [1] ex_muldiv [0] mdu_done
module tb_pipe_hazard_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  pipe_hazard_ctrl_if hz ();

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_redirects, perf_mdu_ops;
`endif

  pipe_hazard_ctrl #(.FENCE_DRAIN_CYCLES(3)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    ,
    .perf_stall_cycles_o (perf_stall_cycles),
    .perf_redirects_o    (perf_redirects),
    .perf_mdu_ops_o      (perf_mdu_ops)
`endif
  );

  // Input patterns
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_LU   = 7'b1000000;
  localparam logic [6:0] I_BR   = 7'b0100000;
  localparam logic [6:0] I_FN   = 7'b0010000;
  localparam logic [6:0] I_EXC  = 7'b0001000;
  localparam logic [6:0] I_MRET = 7'b0000100;
  localparam logic [6:0] I_MD   = 7'b0000010;
  localparam logic [6:0] I_DONE = 7'b0000001;

  // Expected control vectors
  localparam logic [9:0] E_ZERO  = 10'b0000000000;
  localparam logic [9:0] E_STALL = 10'b1100100000; // load-use / fence hold
  localparam logic [9:0] E_MDU0  = 10'b1110010001; // start cycle
  localparam logic [9:0] E_MDUW  = 10'b1110010000; // waiting on MDU
  localparam logic [9:0] E_EXC   = 10'b0001101010; // redirect mtvec
  localparam logic [9:0] E_MRET  = 10'b0001101100; // redirect mepc
  localparam logic [9:0] E_BR    = 10'b0001001000; // redirect branch
  localparam logic [9:0] E_FLAST = 10'b0000100000; // fence retires as NOP

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];

  int exp_stalls = 0;
  int exp_redirs = 0;
  int exp_mdu    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [9:0] observed();
    return {hz.stall_if_o, hz.stall_id_o, hz.stall_ex_o, hz.flush_id_o,
            hz.bubble_ex_o, hz.bubble_mem_o, hz.redirect_o,
            hz.redirect_sel_o, hz.mdu_start_o};
  endfunction

  // One clock cycle: drive after the rising edge, compare at the falling edge
  task automatic cyc(input string tag, input logic rst_v, input logic [6:0] in,
                     input logic [9:0] exp);
    logic [9:0] e;
    @(posedge clock);
    #1;
    reset          = rst_v;
    hz.load_use_i  = in[6];
    hz.branch_i    = in[5];
    hz.fence_i     = in[4];
    hz.exception_i = in[3];
    hz.mret_i      = in[2];
    hz.ex_muldiv_i = in[1];
    hz.mdu_done_i  = in[0];
    exp_q.push_back(exp);
    @(negedge clock);
    e = exp_q.pop_front();
    check(tag, {22'd0, observed()}, {22'd0, e});
    if (!rst_v) begin
      exp_stalls = 0;
      exp_redirs = 0;
      exp_mdu    = 0;
    end else begin
      if (e[9]) exp_stalls++;
      if (e[3]) exp_redirs++;
      if (e[0]) exp_mdu++;
    end
  endtask

  initial begin
    hz.load_use_i  = 1'b0;
    hz.branch_i    = 1'b0;
    hz.fence_i     = 1'b0;
    hz.exception_i = 1'b0;
    hz.mret_i      = 1'b0;
    hz.ex_muldiv_i = 1'b0;
    hz.mdu_done_i  = 1'b0;

    // Reset: outputs stay 0 even with an MDU request pending
    cyc("rst_md",   1'b0, I_MD,  E_ZERO);
    cyc("rst_exc",  1'b0, I_EXC, E_ZERO);
    cyc("idle",     1'b1, I_NONE, E_ZERO);

    // Load-use stalls one cycle, masks branch/fence
    cyc("lu",       1'b1, I_LU, E_STALL);
    cyc("lu_after", 1'b1, I_NONE, E_ZERO);
    cyc("lu_mask",  1'b1, I_LU | I_BR | I_FN, E_STALL);
    cyc("lu_mask2", 1'b1, I_NONE, E_ZERO);

    // MDU op: done arrives 5 cycles after start
    cyc("mdu_c0",   1'b1, I_MD, E_MDU0);
    for (int i = 1; i <= 4; i++) cyc($sformatf("mdu_c%0d", i), 1'b1, I_MD, E_MDUW);
    cyc("mdu_done", 1'b1, I_MD | I_DONE, E_ZERO);
    cyc("mdu_run",  1'b1, I_NONE, E_ZERO);
    cyc("done_run", 1'b1, I_DONE, E_ZERO);

    // Fence: 3 stall cycles, 4 bubble cycles; ID events ignored while draining
    cyc("fence_0",  1'b1, I_FN, E_STALL);
    cyc("fence_1",  1'b1, I_FN | I_BR, E_STALL);
    cyc("fence_2",  1'b1, I_FN | I_EXC, E_STALL);
    cyc("fence_3",  1'b1, I_FN | I_MD, E_FLAST);
    cyc("fence_run",1'b1, I_NONE, E_ZERO);

    // Redirect priorities
    cyc("exc_br",   1'b1, I_EXC | I_BR, E_EXC);
    cyc("mret",     1'b1, I_MRET, E_MRET);
    cyc("exc_mret", 1'b1, I_EXC | I_MRET, E_EXC);
    cyc("branch",   1'b1, I_BR, E_BR);
    cyc("exc_lu",   1'b1, I_EXC | I_LU, E_EXC);
    cyc("br_fence", 1'b1, I_BR | I_FN, E_BR);
    cyc("br_after", 1'b1, I_NONE, E_ZERO);

    // Exception held during MDU wait: no redirect until done
    cyc("mx_c0",    1'b1, I_MD | I_EXC, E_MDU0);
    cyc("mx_c1",    1'b1, I_MD | I_EXC, E_MDUW);
    cyc("mx_c2",    1'b1, I_MD | I_EXC | I_MRET, E_MDUW);
    cyc("mx_done",  1'b1, I_MD | I_EXC | I_DONE, E_ZERO);
    cyc("mx_exc",   1'b1, I_EXC, E_EXC);

    // Reset mid fence drain (counter==2): outputs drop immediately
    cyc("rf_0",     1'b1, I_FN, E_STALL);
    cyc("rf_1",     1'b1, I_FN, E_STALL);
    cyc("rf_rst",   1'b0, I_FN, E_ZERO);
    cyc("rf_rel",   1'b1, I_NONE, E_ZERO);
    cyc("rf_lu",    1'b1, I_LU, E_STALL);
    // Full fresh drain proves the counter restarted cleanly
    cyc("rf2_0",    1'b1, I_FN, E_STALL);
    cyc("rf2_1",    1'b1, I_FN, E_STALL);
    cyc("rf2_2",    1'b1, I_FN, E_STALL);
    cyc("rf2_3",    1'b1, I_FN, E_FLAST);
    cyc("rf2_run",  1'b1, I_NONE, E_ZERO);

    // Reset mid MDU wait: no start pulse on exit
    cyc("rm_0",     1'b1, I_MD, E_MDU0);
    cyc("rm_1",     1'b1, I_MD, E_MDUW);
    cyc("rm_rst",   1'b0, I_MD, E_ZERO);
    cyc("rm_rel",   1'b1, I_NONE, E_ZERO);
    cyc("rm_run",   1'b1, I_DONE, E_ZERO);
    cyc("rm_exc",   1'b1, I_EXC, E_EXC);
    cyc("rm_md",    1'b1, I_MD, E_MDU0);
    cyc("rm_done",  1'b1, I_MD | I_DONE, E_ZERO);
    cyc("rm_end",   1'b1, I_NONE, E_ZERO);

    check("sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    @(posedge clock);
    #1;
    check("perf_stall", perf_stall_cycles, 32'(exp_stalls));
    check("perf_redir", perf_redirects,    32'(exp_redirs));
    check("perf_mdu",   perf_mdu_ops,      32'(exp_mdu));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
